sprite_load_ctrl: RTL

Sequencer that fills the three `sprite_render` texture RAMs (bird, pipe, base) from the SDRAM read path at boot or on request. It requests one source segment at a time from the SDRAM reader, accepts the returned 16-bit word stream with valid/ready flow control, and drives the matching `*_load_en` / `*_load_addr` strobes together with the shared `load_data` bus. It runs in the 50 MHz load clock domain, the same domain as `bird_load_clk`.

---
 rtl/sprite_load_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/sprite_load_ctrl.sv
// sprite_load_ctrl
//
// Fills the three sprite_render texture RAMs (bird, pipe, base) from the SDRAM read path.
// Each segment is requested from the SDRAM reader in turn (seg_req/seg_ack). The returned
// 16-bit word stream (in_valid/in_ready) is then written into the matching RAM, one cycle
// after each accepted word.
//
// Optional feature: define SPRITE_LOAD_TIMEOUT_EN to build a stall counter. It aborts the
// load into DONE with load_err=1 after TIMEOUT_CYC cycles without a seg_ack or a beat.
// Without the macro load_err is tied to 0 and the controller waits indefinitely.
//
// Ports:
//   clk, rst               load clock (50 MHz), synchronous active-high reset
//   start                  single-cycle request to load all three segments
//   busy, done, load_err   status: running / finished (level) / timeout abort
//   seg_req, seg_ack       segment request handshake to the SDRAM reader
//   seg_addr, seg_len      source word address and word count of the requested segment
//   in_data, in_valid      returned word stream
//   in_ready               controller accepts a word (decoded from state only)
//   load_data              registered copy of the accepted word
//   *_load_en/*_load_addr  per-RAM write strobe and address

module sprite_load_ctrl #(
   parameter int unsigned BIRD_WORDS  = 5250,
   parameter int unsigned PIPE_WORDS  = 40000,
   parameter int unsigned BASE_WORDS  = 4800,
   parameter logic [23:0] BIRD_SRC    = 24'h000000,
   parameter logic [23:0] PIPE_SRC    = 24'h002000,
   parameter logic [23:0] BASE_SRC    = 24'h00C000,
   parameter int unsigned TIMEOUT_CYC = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        load_err,
   output logic        seg_req,
   input  logic        seg_ack,
   output logic [23:0] seg_addr,
   output logic [15:0] seg_len,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] load_data,
   output logic        bird_load_en,
   output logic [12:0] bird_load_addr,
   output logic        pipe_load_en,
   output logic [15:0] pipe_load_addr,
   output logic        base_load_en,
   output logic [13:0] base_load_addr
);

   typedef enum logic [1:0] {StIdle, StReq, StXfer, StDone} state_e;

   localparam logic [15:0] BirdLen = 16'(BIRD_WORDS);
   localparam logic [15:0] PipeLen = 16'(PIPE_WORDS);
   localparam logic [15:0] BaseLen = 16'(BASE_WORDS);

   localparam logic [1:0] SegBird = 2'd0;
   localparam logic [1:0] SegPipe = 2'd1;
   localparam logic [1:0] SegBase = 2'd2;

   function automatic logic [15:0] len_of(input logic [1:0] idx);
      case (idx)
         SegBird: len_of = BirdLen;
         SegPipe: len_of = PipeLen;
         default: len_of = BaseLen;
      endcase
   endfunction

   function automatic logic [23:0] src_of(input logic [1:0] idx);
      case (idx)
         SegBird: src_of = BIRD_SRC;
         SegPipe: src_of = PIPE_SRC;
         default: src_of = BASE_SRC;
      endcase
   endfunction

   state_e      state_q, state_d;
   logic [1:0]  seg_idx_q, seg_idx_d;
   logic [15:0] cnt_q, cnt_d;
   logic [23:0] seg_addr_q, seg_addr_d;
   logic [15:0] seg_len_q, seg_len_d;

   // Write pipeline: one registered stage between an accepted beat and its RAM strobe.
   logic        wr_en_q;
   logic [1:0]  wr_seg_q;
   logic [15:0] wr_addr_q;
   logic [15:0] load_data_q;

   logic        beat;

`ifdef SPRITE_LOAD_TIMEOUT_EN
   localparam logic [15:0] TimeoutCyc = 16'(TIMEOUT_CYC);
   logic [15:0] stall_q, stall_d;
   logic        load_err_q, load_err_d;
`else
   logic        unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

   // in_ready depends on registered state only, so a beat is just valid while in XFER.
   assign beat = (state_q == StXfer) && in_valid;

   always_comb begin
      state_d    = state_q;
      seg_idx_d  = seg_idx_q;
      cnt_d      = cnt_q;
      seg_addr_d = seg_addr_q;
      seg_len_d  = seg_len_q;
`ifdef SPRITE_LOAD_TIMEOUT_EN
      stall_d    = stall_q;
      load_err_d = load_err_q;
`endif

      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d    = StReq;
               seg_idx_d  = SegBird;
               seg_addr_d = BIRD_SRC;
               seg_len_d  = BirdLen;
`ifdef SPRITE_LOAD_TIMEOUT_EN
               stall_d    = '0;
               load_err_d = 1'b0;
`endif
            end
         end
         StReq: begin
            if (seg_ack) begin
               state_d = StXfer;
               cnt_d   = '0;
            end
         end
         StXfer: begin
            if (beat) begin
               cnt_d = cnt_q + 16'd1;
               if (cnt_q == seg_len_q - 16'd1) begin
                  if (seg_idx_q == SegBase) begin
                     state_d = StDone;
                  end else begin
                     state_d    = StReq;
                     seg_idx_d  = seg_idx_q + 2'd1;
                     seg_addr_d = src_of(seg_idx_q + 2'd1);
                     seg_len_d  = len_of(seg_idx_q + 2'd1);
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase

`ifdef SPRITE_LOAD_TIMEOUT_EN
      // Stall counter: any handshake progress restarts it; reaching the limit aborts.
      if (state_q == StReq || state_q == StXfer) begin
         if ((state_q == StReq && seg_ack) || beat) begin
            stall_d = '0;
         end else if (stall_q == TimeoutCyc) begin
            state_d    = StDone;
            load_err_d = 1'b1;
         end else begin
            stall_d = stall_q + 16'd1;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         seg_idx_q   <= '0;
         cnt_q       <= '0;
         seg_addr_q  <= '0;
         seg_len_q   <= '0;
         wr_en_q     <= 1'b0;
         wr_seg_q    <= '0;
         wr_addr_q   <= '0;
         load_data_q <= '0;
`ifdef SPRITE_LOAD_TIMEOUT_EN
         stall_q     <= '0;
         load_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         seg_idx_q  <= seg_idx_d;
         cnt_q      <= cnt_d;
         seg_addr_q <= seg_addr_d;
         seg_len_q  <= seg_len_d;
         wr_en_q    <= beat;
         if (beat) begin
            wr_seg_q    <= seg_idx_q;
            wr_addr_q   <= cnt_q;
            load_data_q <= in_data;
         end
`ifdef SPRITE_LOAD_TIMEOUT_EN
         stall_q    <= stall_d;
         load_err_q <= load_err_d;
`endif
      end
   end

   assign busy     = (state_q == StReq) || (state_q == StXfer);
   assign done     = (state_q == StDone);
   assign seg_req  = (state_q == StReq);
   assign in_ready = (state_q == StXfer);
   assign seg_addr = seg_addr_q;
   assign seg_len  = seg_len_q;

`ifdef SPRITE_LOAD_TIMEOUT_EN
   assign load_err = load_err_q;
`else
   assign load_err = 1'b0;
`endif

   assign load_data      = load_data_q;
   assign bird_load_en   = wr_en_q && (wr_seg_q == SegBird);
   assign pipe_load_en   = wr_en_q && (wr_seg_q == SegPipe);
   assign base_load_en   = wr_en_q && (wr_seg_q == SegBase);
   assign bird_load_addr = wr_addr_q[12:0];
   assign pipe_load_addr = wr_addr_q;
   assign base_load_addr = wr_addr_q[13:0];

endmodule
